key_entry_buf: RTL and testbench

Downstream consumer of the 4x4 matrix keypad scanner. Takes the scanner's key-pressed level and 4-bit key code, synchronises and debounces them, and turns each accepted press into exactly one action. Maintains a DIGITS-long hex/BCD entry buffer that drives the seven-segment display stage. Command keys (C-F) are issued as single-cycle command pulses to the control logic.

---
 rtl/key_pkg.sv | 19 +
 rtl/key_debounce.sv | 94 +++++++++
 rtl/key_entry_buf.sv | 111 +++++++++++
 tb/tb_key_entry_buf.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the keypad entry path: debounce FSM states and key codes.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } deb_state_e;

  localparam logic [3:0] KEY_CLR      = 4'hA;
  localparam logic [3:0] KEY_BKSP     = 4'hB;
  localparam logic [3:0] KEY_CMD_BASE = 4'hC;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'h9);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises the scanner outputs and accepts one press per debounced key-down,
// strobing acc_pulse_o on the edge where the press is accepted.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       key_pressed_i,
  input  logic [3:0] key_val_i,
  output logic       acc_pulse_o,
  output logic [3:0] acc_val_o
);

  // Counter runs 0..DEB_CYCLES-2 and the accept happens on the edge that would
  // reach DEB_CYCLES-1, giving 2 + DEB_CYCLES cycles from raw press to event.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 2);

  logic       kp_meta_q, kp_s_q;
  logic [3:0] kv_meta_q, kv_s_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_meta_q <= 1'b0;
      kp_s_q    <= 1'b0;
      kv_meta_q <= 4'h0;
      kv_s_q    <= 4'h0;
    end else begin
      kp_meta_q <= key_pressed_i;
      kp_s_q    <= kp_meta_q;
      kv_meta_q <= key_val_i;
      kv_s_q    <= kv_meta_q;
    end
  end

  deb_state_e       state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= 4'h0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (kp_s_q) begin
            cand_q  <= kv_s_q;
            cnt_q   <= '0;
            state_q <= ST_DEB_PRESS;
          end
        end
        ST_DEB_PRESS: begin
          if (!kp_s_q) begin
            state_q <= ST_IDLE;
          end else if (kv_s_q != cand_q) begin
            cand_q <= kv_s_q;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_HELD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (!kp_s_q) begin
            cnt_q   <= '0;
            state_q <= ST_DEB_REL;
          end
        end
        ST_DEB_REL: begin
          if (kp_s_q) begin
            state_q <= ST_HELD;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign acc_pulse_o = (state_q == ST_DEB_PRESS) && kp_s_q &&
                       (kv_s_q == cand_q) && (cnt_q == CNT_LAST);
  assign acc_val_o   = cand_q;

endmodule

// File: rtl/key_entry_buf.sv
// Keypad entry buffer: digits shift into a DIGITS-long buffer, A clears,
// B backspaces, C-F are issued as command pulses with a snapshot of the buffer.
module key_entry_buf
  import key_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20,
  parameter int CLR_ON_CMD = 1
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                key_pressed,
  input  logic [3:0]          key_val,
  output logic [4*DIGITS-1:0] entry,
  output logic [3:0]          digit_cnt,
  output logic                key_event,
  output logic                overflow,
  output logic                cmd_valid,
  output logic [1:0]          cmd_code,
  output logic [4*DIGITS-1:0] cmd_data
);

  localparam int         EW      = 4 * DIGITS;
  localparam logic [3:0] DIG_MAX = 4'(DIGITS);

  logic       acc_pulse;
  logic [3:0] acc_val;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .key_pressed_i (key_pressed),
    .key_val_i     (key_val),
    .acc_pulse_o   (acc_pulse),
    .acc_val_o     (acc_val)
  );

  logic [EW-1:0] entry_q, entry_d, cmd_data_q, cmd_data_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    cmd_code_q, cmd_code_d;
  logic          key_event_q, overflow_q, overflow_d, cmd_valid_q, cmd_valid_d;

  always_comb begin
    entry_d     = entry_q;
    cnt_d       = cnt_q;
    cmd_data_d  = cmd_data_q;
    cmd_code_d  = cmd_code_q;
    overflow_d  = 1'b0;
    cmd_valid_d = 1'b0;
    if (acc_pulse) begin
      if (is_digit(acc_val)) begin
        if (cnt_q < DIG_MAX) begin
          entry_d = (entry_q << 4) | EW'(acc_val);
          cnt_d   = cnt_q + 4'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (acc_val == KEY_CLR) begin
        entry_d = '0;
        cnt_d   = 4'd0;
      end else if (acc_val == KEY_BKSP) begin
        if (cnt_q != 4'd0) begin
          entry_d = entry_q >> 4;
          cnt_d   = cnt_q - 4'd1;
        end
      end else begin
        // Command keys C..F map to codes 0..3 via their low two bits.
        cmd_valid_d = 1'b1;
        cmd_code_d  = acc_val[1:0];
        cmd_data_d  = entry_q;
        if (CLR_ON_CMD != 0) begin
          entry_d = '0;
          cnt_d   = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q     <= '0;
      cnt_q       <= 4'd0;
      cmd_data_q  <= '0;
      cmd_code_q  <= 2'd0;
      key_event_q <= 1'b0;
      overflow_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
    end else begin
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      cmd_data_q  <= cmd_data_d;
      cmd_code_q  <= cmd_code_d;
      key_event_q <= acc_pulse;
      overflow_q  <= overflow_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign entry     = entry_q;
  assign digit_cnt = cnt_q;
  assign key_event = key_event_q;
  assign overflow  = overflow_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_key_entry_buf.sv
// Directed bench for key_entry_buf with a short debounce window (DEB_CYCLES=4).
module tb_key_entry_buf;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_pressed = 1'b0;
  logic [3:0]  key_val = 4'h0;
  logic [15:0] entry, cmd_data;
  logic [3:0]  digit_cnt;
  logic        key_event, overflow, cmd_valid;
  logic [1:0]  cmd_code;

  key_entry_buf #(
    .DIGITS(4), .DEB_CYCLES(4), .CNT_W(3), .CLR_ON_CMD(1)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .key_pressed (key_pressed),
    .key_val     (key_val),
    .entry       (entry),
    .digit_cnt   (digit_cnt),
    .key_event   (key_event),
    .overflow    (overflow),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_data    (cmd_data)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0, n_err = 0;
  int ev_cnt = 0, ov_cnt = 0, cmd_cnt = 0;

  always @(negedge sys_clk) begin
    if (key_event) ev_cnt++;
    if (overflow)  ov_cnt++;
    if (cmd_valid) cmd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Press v for 'hold' cycles then release for 'rel' cycles; optionally check latency.
  task automatic press(input logic [3:0] v, input int hold, input int rel, input bit lat_chk);
    int lat;
    lat = -1;
    key_val = v;
    key_pressed = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      @(negedge sys_clk);
      if (key_event && lat < 0) lat = i;
    end
    key_pressed = 1'b0;
    repeat (rel) @(negedge sys_clk);
    if (lat_chk) chk("latency", lat, 6);
  endtask

  int e0, o0, c0, lat;

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_entry", entry, 0);
    chk("rst_cnt", digit_cnt, 0);
    chk("rst_flags", {key_event, overflow, cmd_valid}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1: three digits, latency checked on each
    press(4'h1, 20, 20, 1'b1);
    press(4'h2, 20, 20, 1'b1);
    press(4'h3, 20, 20, 1'b1);
    chk("t1_entry", entry, 16'h0123);
    chk("t1_cnt", digit_cnt, 3);
    chk("t1_events", ev_cnt, 3);

    // 2: glitchy press of 5 then release bounce
    press(4'hA, 12, 12, 1'b0);
    e0 = ev_cnt;
    key_val = 4'h5;
    for (int i = 0; i < 10; i++) begin
      key_pressed = (i % 2 == 0);
      @(negedge sys_clk);
    end
    key_pressed = 1'b1;
    repeat (12) @(negedge sys_clk);
    key_pressed = 1'b0;
    repeat (2) @(negedge sys_clk);
    key_pressed = 1'b1;
    @(negedge sys_clk);
    key_pressed = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("t2_events", ev_cnt - e0, 1);
    chk("t2_entry", entry, 16'h0005);

    // 3: overflow, backspace, clear, backspace on empty
    press(4'hA, 12, 12, 1'b0);
    press(4'h1, 12, 12, 1'b0);
    press(4'h2, 12, 12, 1'b0);
    press(4'h3, 12, 12, 1'b0);
    press(4'h4, 12, 12, 1'b0);
    chk("t3_full", entry, 16'h1234);
    o0 = ov_cnt;
    press(4'h9, 12, 12, 1'b0);
    chk("t3_ovf", ov_cnt - o0, 1);
    chk("t3_ovf_entry", entry, 16'h1234);
    chk("t3_ovf_cnt", digit_cnt, 4);
    press(4'hB, 12, 12, 1'b0);
    chk("t3_bksp_entry", entry, 16'h0123);
    chk("t3_bksp_cnt", digit_cnt, 3);
    press(4'hA, 12, 12, 1'b0);
    chk("t3_clr", {entry, digit_cnt}, 0);
    e0 = ev_cnt;
    press(4'hB, 12, 12, 1'b0);
    chk("t3_bksp0_ev", ev_cnt - e0, 1);
    chk("t3_bksp0", {entry, digit_cnt}, 0);

    // 4: command E with 42 entered
    press(4'h4, 12, 12, 1'b0);
    press(4'h2, 12, 12, 1'b0);
    c0 = cmd_cnt;
    key_val = 4'hE;
    key_pressed = 1'b1;
    repeat (6) @(negedge sys_clk);
    chk("t4_cmd_valid", cmd_valid, 1);
    chk("t4_cmd_code", cmd_code, 2);
    chk("t4_cmd_data", cmd_data, 16'h0042);
    chk("t4_entry_clr", {entry, digit_cnt}, 0);
    @(negedge sys_clk);
    chk("t4_cmd_pulse", cmd_valid, 0);
    repeat (6) @(negedge sys_clk);
    key_pressed = 1'b0;
    repeat (12) @(negedge sys_clk);
    chk("t4_cmd_cnt", cmd_cnt - c0, 1);
    chk("t4_cmd_hold", {cmd_code, cmd_data}, {2'd2, 16'h0042});

    // 5: long hold with key_val change mid-hold
    e0 = ev_cnt;
    key_val = 4'h7;
    key_pressed = 1'b1;
    repeat (50) @(negedge sys_clk);
    key_val = 4'h8;
    repeat (50) @(negedge sys_clk);
    key_pressed = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("t5_events", ev_cnt - e0, 1);
    chk("t5_entry", entry, 16'h0007);
    chk("t5_cnt", digit_cnt, 1);

    // 6: reset during DEB_PRESS with key held
    e0 = ev_cnt;
    key_val = 4'h3;
    key_pressed = 1'b1;
    repeat (4) @(negedge sys_clk);
    rst_n = 1'b0;
    @(negedge sys_clk);
    chk("t6_rst_out", {entry, digit_cnt, cmd_code, cmd_data}, 0);
    chk("t6_rst_flags", {key_event, overflow, cmd_valid}, 0);
    @(negedge sys_clk);
    chk("t6_no_ev", ev_cnt - e0, 0);
    rst_n = 1'b1;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge sys_clk);
      if (key_event && lat < 0) lat = i;
    end
    chk("t6_latency", lat, 6);
    key_pressed = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("t6_events", ev_cnt - e0, 1);
    chk("t6_entry", entry, 16'h0003);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
